// File: rtl/time_digit_splitter_pkg.sv
// Shared constants, types and state encoding for the centisecond-to-BCD time splitter.
package time_split_pkg;

    localparam int unsigned CS_PER_HOUR   = 360000;
    localparam int unsigned CS_PER_MIN    = 6000;
    localparam int unsigned CS_PER_SEC    = 100;
    localparam int unsigned HOURS_PER_DAY = 24;
    localparam int unsigned DIGIT_BASE    = 10;
    localparam logic [3:0]  BLANK_DIGIT   = 4'hF;

    typedef enum logic {
        ST_IDLE,
        ST_ITER
    } split_state_e;

    typedef logic [7:0][3:0] digit_vec_t;

endpackage

// File: rtl/time_digit_splitter_if.sv
// Request/result bundle between the time source, the splitter and the display scanner.
interface time_digit_splitter_if
    import time_split_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] systime;
    logic             busy;
    logic             done;
    digit_vec_t       digits;

    modport master (output start, output systime, input busy, input done, input digits);
    modport slave  (input start, input systime, output busy, output done, output digits);
endinterface

// File: rtl/time_digit_splitter_divider.sv
// Restoring divider: one load cycle then WIDTH iterate cycles, one quotient bit per cycle.
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ready
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // quo_q doubles as the dividend shift register; bit WIDTH of trial is the borrow
    always_comb begin
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        if (load) begin
            quo_d   = dividend;
            rem_d   = '0;
            dvs_d   = divisor;
            cnt_d   = CNT_W'(WIDTH);
            ready_d = 1'b0;
        end else if (cnt_q != '0) begin
            if (!trial[WIDTH]) begin
                rem_d = trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = shifted[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d   = cnt_q - CNT_W'(1);
            ready_d = (cnt_q == CNT_W'(1));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign ready     = ready_q;
endmodule

// File: rtl/time_digit_splitter.sv
// Centisecond count to HH:MM:SS.cc BCD digits through eight chained divisions on one divider.
// Define SPLITTER_BLANK_EN to show the hour tens digit as blank code when hours < 10.
module time_digit_splitter
    import time_split_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    time_digit_splitter_if.slave  bus
);
    split_state_e     state_q, state_d;
    logic [2:0]       step_q, step_d;
    logic [WIDTH-1:0] r1_q, r1_d;
    logic [WIDTH-1:0] hours_q, hours_d;
    logic [WIDTH-1:0] minutes_q, minutes_d;
    logic [WIDTH-1:0] seconds_q, seconds_d;
    logic [WIDTH-1:0] centis_q, centis_d;
    digit_vec_t       stage_q, stage_d;
    digit_vec_t       digits_q, digits_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             div_load_c;
    logic [WIDTH-1:0] div_dividend_c;
    logic [WIDTH-1:0] div_divisor_c;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;
    logic             div_ready;

    seq_divider #(.WIDTH(WIDTH)) u_div (
        .clock     (clock),
        .reset     (reset),
        .load      (div_load_c),
        .dividend  (div_dividend_c),
        .divisor   (div_divisor_c),
        .quotient  (div_quo),
        .remainder (div_rem),
        .ready     (div_ready)
    );

    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.start)                       state_d = ST_ITER;
            ST_ITER: if (div_ready && step_q == 3'd7)     state_d = ST_IDLE;
            default:                                      state_d = ST_IDLE;
        endcase
    end

    // Each finished division is captured on the same edge that loads the next one
    always_comb begin
        step_d         = step_q;
        r1_d           = r1_q;
        hours_d        = hours_q;
        minutes_d      = minutes_q;
        seconds_d      = seconds_q;
        centis_d       = centis_q;
        stage_d        = stage_q;
        digits_d       = digits_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        div_load_c     = 1'b0;
        div_dividend_c = '0;
        div_divisor_c  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    div_load_c     = 1'b1;
                    div_dividend_c = bus.systime;
                    div_divisor_c  = WIDTH'(CS_PER_HOUR);
                    step_d         = 3'd0;
                    busy_d         = 1'b1;
                end
            end
            ST_ITER: begin
                if (div_ready) begin
                    step_d = step_q + 3'd1;
                    unique case (step_q)
                        3'd0: begin
                            r1_d           = div_rem;
                            div_load_c     = 1'b1;
                            div_dividend_c = div_quo;
                            div_divisor_c  = WIDTH'(HOURS_PER_DAY);
                        end
                        3'd1: begin
                            hours_d        = div_rem;
                            div_load_c     = 1'b1;
                            div_dividend_c = r1_q;
                            div_divisor_c  = WIDTH'(CS_PER_MIN);
                        end
                        3'd2: begin
                            minutes_d      = div_quo;
                            div_load_c     = 1'b1;
                            div_dividend_c = div_rem;
                            div_divisor_c  = WIDTH'(CS_PER_SEC);
                        end
                        3'd3: begin
                            seconds_d      = div_quo;
                            centis_d       = div_rem;
                            div_load_c     = 1'b1;
                            div_dividend_c = hours_q;
                            div_divisor_c  = WIDTH'(DIGIT_BASE);
                        end
                        3'd4: begin
                            stage_d[7]     = div_quo[3:0];
                            stage_d[6]     = div_rem[3:0];
                            div_load_c     = 1'b1;
                            div_dividend_c = minutes_q;
                            div_divisor_c  = WIDTH'(DIGIT_BASE);
                        end
                        3'd5: begin
                            stage_d[5]     = div_quo[3:0];
                            stage_d[4]     = div_rem[3:0];
                            div_load_c     = 1'b1;
                            div_dividend_c = seconds_q;
                            div_divisor_c  = WIDTH'(DIGIT_BASE);
                        end
                        3'd6: begin
                            stage_d[3]     = div_quo[3:0];
                            stage_d[2]     = div_rem[3:0];
                            div_load_c     = 1'b1;
                            div_dividend_c = centis_q;
                            div_divisor_c  = WIDTH'(DIGIT_BASE);
                        end
                        default: begin
                            digits_d    = stage_q;
                            digits_d[1] = div_quo[3:0];
                            digits_d[0] = div_rem[3:0];
`ifdef SPLITTER_BLANK_EN
                            if (stage_q[7] == 4'h0) digits_d[7] = BLANK_DIGIT;
`else
                            digits_d[7] = stage_q[7];
`endif
                            done_d = 1'b1;
                            busy_d = 1'b0;
                        end
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            step_q    <= '0;
            r1_q      <= '0;
            hours_q   <= '0;
            minutes_q <= '0;
            seconds_q <= '0;
            centis_q  <= '0;
            stage_q   <= '0;
            digits_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            step_q    <= step_d;
            r1_q      <= r1_d;
            hours_q   <= hours_d;
            minutes_q <= minutes_d;
            seconds_q <= seconds_d;
            centis_q  <= centis_d;
            stage_q   <= stage_d;
            digits_q  <= digits_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.digits = digits_q;
endmodule

// File: tb/tb_time_digit_splitter.sv
// Scoreboard bench for time_digit_splitter: directed conversions, latency, drop/retrigger and reset abort.
module tb_time_digit_splitter;
    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    logic [31:0] sb[$];

    time_digit_splitter_if #(.WIDTH(32)) bus ();

    time_digit_splitter #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] adj(input logic [31:0] e);
        logic [31:0] r;
        r = e;
`ifdef SPLITTER_BLANK_EN
        if (r[31:28] == 4'h0) r[31:28] = 4'hF;
`endif
        return r;
    endfunction

    // Monitor: every done pulse pops one expected digit vector
    always @(negedge clock) begin
        if (!reset && bus.done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected_done: got %h expected no done", bus.digits);
            end else begin
                chk("sb_digits", bus.digits, sb.pop_front());
            end
        end
    end

    task automatic wait_done(output int c, output bit ok);
        ok = 1'b0;
        c  = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (bus.done === 1'b1) begin
                c  = cyc;
                ok = 1'b1;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL done_timeout: got no done expected done within 400 cycles");
    endtask

    task automatic run_conv(input logic [31:0] t, input logic [31:0] exp_raw);
        int c0, c1;
        bit ok;
        @(negedge clock);
        chk("busy_before", 32'(bus.busy), 32'd0);
        bus.start   = 1'b1;
        bus.systime = t;
        sb.push_back(adj(exp_raw));
        @(negedge clock);
        c0 = cyc;
        bus.start = 1'b0;
        chk("busy_rise", 32'(bus.busy), 32'd1);
        wait_done(c1, ok);
        if (ok) begin
            chk("latency", 32'(c1 - c0), 32'd264);
            chk("busy_at_done", 32'(bus.busy), 32'd0);
            @(negedge clock);
            chk("done_pulse", 32'(bus.done), 32'd0);
            chk("busy_after", 32'(bus.busy), 32'd0);
        end
    endtask

    initial begin
        int c1, c2, dc;
        bit ok;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.systime = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_digits", bus.digits, 32'd0);
        reset = 1'b0;

        run_conv(32'd0,          32'h0000_0000);
        run_conv(32'd12345,      32'h0002_0345);
        run_conv(32'd8639999,    32'h2359_5999);
        run_conv(32'd8640000,    32'h0000_0000);
        run_conv(32'hFFFF_FFFF,  32'h0227_5295);

        // start and systime changes while busy are dropped
        dc = done_cnt;
        @(negedge clock);
        bus.start   = 1'b1;
        bus.systime = 32'd12345;
        sb.push_back(adj(32'h0002_0345));
        @(negedge clock);
        bus.start   = 1'b0;
        bus.systime = 32'd777;
        repeat (98) @(negedge clock);
        bus.start   = 1'b1;
        bus.systime = 32'd8639999;
        @(negedge clock);
        bus.start   = 1'b0;
        wait_done(c1, ok);
        repeat (300) @(negedge clock);
        chk("single_done", 32'(done_cnt - dc), 32'd1);

        // start held high retriggers back to back
        @(negedge clock);
        bus.start   = 1'b1;
        bus.systime = 32'd100;
        sb.push_back(adj(32'h0000_0100));
        sb.push_back(adj(32'h0000_0100));
        wait_done(c1, ok);
        @(negedge clock);
        bus.start = 1'b0;
        wait_done(c2, ok);
        if (ok) chk("retrigger_period", 32'(c2 - c1), 32'd265);

        // reset mid-conversion aborts without a done
        repeat (3) @(negedge clock);
        bus.start   = 1'b1;
        bus.systime = 32'd8639999;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (148) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_digits", bus.digits, 32'd0);
        reset = 1'b0;
        repeat (300) @(negedge clock);
        run_conv(32'd12345, 32'h0002_0345);

        repeat (5) @(negedge clock);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1);
    end
endmodule
